// File: rtl/noc_step_sequencer.sv
// Closed-loop step sequencer for the router array: Init, route-table load, then
// LoadStaging/Phase0/Phase1/CopyStaging per NoC cycle, paced by the routers' done bits.
module noc_step_sequencer #(
  parameter int NUM_ROUTERS  = 4,
  parameter int OP_SIZE      = 3,
  parameter int CYCLE_SIZE   = 16,
  parameter int RT_ENTRIES   = 8,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CYCLE_SIZE-1:0]          num_cycles,
  input  logic [NUM_ROUTERS-1:0]         done_in,
  output logic [OP_SIZE-1:0]             op,
  output logic [CYCLE_SIZE-1:0]          in_cycle,
  output logic [$clog2(NUM_ROUTERS)-1:0] rt_router,
  output logic [$clog2(RT_ENTRIES)-1:0]  rt_entry,
  output logic                           busy,
  output logic                           finished,
  output logic                           timeout_err
);

  localparam int RTR_W  = $clog2(NUM_ROUTERS);
  localparam int ENT_W  = $clog2(RT_ENTRIES);
  localparam int WAIT_W = $clog2(DONE_TIMEOUT + 1);

  localparam logic [OP_SIZE-1:0] OP_NOP    = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_INIT   = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_LOADRT = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_LSTAGE = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_PH0    = OP_SIZE'(4);
  localparam logic [OP_SIZE-1:0] OP_PH1    = OP_SIZE'(5);
  localparam logic [OP_SIZE-1:0] OP_COPY   = OP_SIZE'(6);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_LOADRT, S_LSTAGE, S_PH0, S_PH1, S_COPY, S_FINISH, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [OP_SIZE-1:0]    op_d;
  logic [CYCLE_SIZE-1:0] num_q;
  logic [WAIT_W-1:0]     wait_q;
  logic                  all_done;
  logic                  last_entry;

  // done_in is level-sampled: only a cycle where every bit is high counts, and
  // never in the issue cycle of a phase (wait_q == 0).
  assign all_done   = &done_in;
  assign last_entry = (rt_router == RTR_W'(NUM_ROUTERS - 1)) &&
                      (rt_entry == ENT_W'(RT_ENTRIES - 1));

  always_comb begin
    state_d = state_q;
    op_d    = OP_NOP;
    case (state_q)
      S_IDLE:   if (start) state_d = S_INIT;
      S_INIT:   state_d = S_LOADRT;
      S_LOADRT: if (last_entry) state_d = (num_q == '0) ? S_FINISH : S_LSTAGE;
      S_LSTAGE: state_d = S_PH0;
      S_PH0, S_PH1: begin
        if (wait_q != '0 && all_done)
          state_d = (state_q == S_PH0) ? S_PH1 : S_COPY;
        else if (wait_q == WAIT_W'(DONE_TIMEOUT))
          state_d = S_ERROR;
      end
      S_COPY:   state_d = (in_cycle == num_q) ? S_FINISH : S_LSTAGE;
      S_FINISH: state_d = S_IDLE;
      S_ERROR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    case (state_d)
      S_INIT:   op_d = OP_INIT;
      S_LOADRT: op_d = OP_LOADRT;
      S_LSTAGE: op_d = OP_LSTAGE;
      S_PH0:    op_d = OP_PH0;
      S_PH1:    op_d = OP_PH1;
      S_COPY:   op_d = OP_COPY;
      default:  op_d = OP_NOP;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op          <= OP_NOP;
      in_cycle    <= '0;
      rt_router   <= '0;
      rt_entry    <= '0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      timeout_err <= 1'b0;
      num_q       <= '0;
      wait_q      <= '0;
    end else begin
      state_q  <= state_d;
      op       <= op_d;
      busy     <= (state_d != S_IDLE) && (state_d != S_ERROR);
      finished <= (state_d == S_FINISH);

      if (state_q == S_IDLE && start) begin
        num_q       <= num_cycles;
        timeout_err <= 1'b0;
      end
      if (state_d == S_ERROR) timeout_err <= 1'b1;

      if (state_d == S_INIT)      in_cycle <= '0;
      else if (state_d == S_COPY) in_cycle <= in_cycle + 1'b1;

      if (state_d != state_q)
        wait_q <= '0;
      else if ((state_q == S_PH0 || state_q == S_PH1) && wait_q != WAIT_W'(DONE_TIMEOUT))
        wait_q <= wait_q + 1'b1;

      // Indices sit at (0,0) outside LoadRt so each load starts from the first entry.
      if (state_q == S_LOADRT && state_d == S_LOADRT) begin
        if (rt_entry == ENT_W'(RT_ENTRIES - 1)) begin
          rt_entry  <= '0;
          rt_router <= rt_router + 1'b1;
        end else begin
          rt_entry <= rt_entry + 1'b1;
        end
      end else begin
        rt_entry  <= '0;
        rt_router <= '0;
      end
    end
  end

endmodule
